// File: rtl/ccff_readback_pkg.sv
// ccff_readback_pkg
// Shared definitions for the configuration-chain readback controller.
//   DATA_W_DEF / LEN_W_DEF : default readback word width and chain-length width
//   state_e                : controller FSM state encoding
package ccff_readback_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int LEN_W_DEF  = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_FINISH = 2'd3
  } state_e;

endpackage

// File: rtl/ccff_readback_packer.sv
// ccff_readback_packer
// Serial-to-parallel packer, LSB first.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   bit_i       : serial data bit
//   valid_i     : capture bit_i on this edge
//   clear_i     : discard the accumulator on this edge (wins over valid_i)
//   word_o      : accumulator with the current bit already merged in, so the
//                 consumer can load a completed word on the capturing edge
//   full_o      : the next captured bit completes a DATA_W-bit word
module ccff_readback_packer
  import ccff_readback_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bit_i,
  input  logic              valid_i,
  input  logic              clear_i,
  output logic [DATA_W-1:0] word_o,
  output logic              full_o
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic [DATA_W-1:0] acc_q;
  logic [IDX_W-1:0]  idx_q;

  // full_o depends only on registered state, so the controller can use it to
  // decide the shift enable without forming a combinational loop.
  assign full_o = (idx_q == IDX_W'(DATA_W - 1));

  always_comb begin
    word_o = acc_q;
    if (valid_i) word_o[idx_q] = bit_i;
  end

  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      acc_q <= '0;
      idx_q <= '0;
    end else if (valid_i) begin
      if (full_o) begin
        acc_q <= '0;
        idx_q <= '0;
      end else begin
        acc_q <= word_o;
        idx_q <= idx_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ccff_readback_ctrl.sv
// ccff_readback_ctrl
// Reads a configuration flip-flop chain back serially and delivers it as
// DATA_W-bit words over a valid/ready port.
// Ports:
//   clk, reset         : clock, synchronous active-high reset
//   start              : request a pass (sampled in IDLE only)
//   chain_len          : number of flip-flops in the chain (0 = empty pass)
//   ccff_tail          : serial output of the last chain flip-flop
//   shift_en           : chain shift enable, one bit per edge while high
//   ccff_head          : serial input into the first chain flip-flop
//   rd_data / rd_valid : output word and its valid flag
//   rd_ready           : consumer accepts rd_data
//   busy               : high in every state except IDLE
//   done               : one-cycle pulse when a pass completes
//   dbg_state          : current FSM state
// Handshake: a word transfers on a rising edge where rd_valid and rd_ready
// are both high; rd_data is held stable while rd_valid=1 and rd_ready=0.
// Build option: define CCFF_READBACK_RESTORE_EN to recirculate the tail into
// the head during shifting so a full pass leaves the chain unchanged;
// otherwise zeros are shifted in and the readback is destructive.
module ccff_readback_ctrl
  import ccff_readback_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [LEN_W-1:0]  chain_len,
  input  logic              ccff_tail,
  output logic              shift_en,
  output logic              ccff_head,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              busy,
  output logic              done,
  output logic [1:0]        dbg_state
);

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   count_q, count_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [DATA_W-1:0]  rd_data_q, rd_data_d;
  logic               rd_valid_q, rd_valid_d;

  logic [DATA_W-1:0]  pk_word;
  logic               pk_full;
  logic               pk_clear;
  logic               last_bit;
  logic               word_done;
  logic               out_free;
  logic               stall;

  assign last_bit  = (({1'b0, count_q} + (LEN_W + 1)'(1)) == {1'b0, len_q});
  assign word_done = pk_full || last_bit;
  assign out_free  = !rd_valid_q || rd_ready;
  // Hold the chain still when the bit about to be captured would complete a
  // word that has nowhere to go; nothing is captured, so nothing is lost.
  assign stall     = word_done && !out_free;
  // Gated by reset so an aborting reset does not advance the chain once more.
  assign shift_en  = (state_q == ST_SHIFT) && !reset && !stall;
  assign pk_clear  = ((state_q == ST_IDLE) && start) || (shift_en && last_bit);

  ccff_readback_packer #(
    .DATA_W (DATA_W)
  ) u_packer (
    .clk     (clk),
    .reset   (reset),
    .bit_i   (ccff_tail),
    .valid_i (shift_en),
    .clear_i (pk_clear),
    .word_o  (pk_word),
    .full_o  (pk_full)
  );

`ifdef CCFF_READBACK_RESTORE_EN
  assign ccff_head = shift_en & ccff_tail;
`else
  assign ccff_head = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    len_d      = len_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_valid_q;

    if (rd_valid_q && rd_ready) rd_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (chain_len != '0) begin
            len_d   = chain_len;
            count_d = '0;
            state_d = ST_SHIFT;
          end else begin
            state_d = ST_FINISH;
          end
        end
      end
      ST_SHIFT: begin
        if (shift_en) begin
          count_d = count_q + 1'b1;
          if (word_done) begin
            rd_data_d  = pk_word;
            rd_valid_d = 1'b1;
          end
          if (last_bit) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (out_free) state_d = ST_FINISH;
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      len_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      len_q      <= len_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_FINISH);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ccff_readback_ctrl.sv
// tb_ccff_readback_ctrl
// Directed bench for ccff_readback_ctrl: a behavioural chain model feeds
// ccff_tail, expected words are queued when a pass is launched and a
// negedge monitor pops and compares them on every transfer.
module tb_ccff_readback_ctrl;

  localparam int DW = 32;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [LW-1:0] chain_len;
  logic          ccff_tail;
  logic          shift_en;
  logic          ccff_head;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_ready;
  logic          busy;
  logic          done;
  logic [1:0]    dbg_state;

  ccff_readback_ctrl #(.DATA_W(DW), .LEN_W(LW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .chain_len (chain_len),
    .ccff_tail (ccff_tail),
    .shift_en  (shift_en),
    .ccff_head (ccff_head),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- chain model ----------------
  logic [127:0] chain_q;
  logic [127:0] chain_nxt;
  logic [127:0] load_val;
  logic         load_req = 1'b0;
  int           model_len = 1;

  always @(posedge clk) begin
    if (load_req) begin
      chain_q <= load_val;
    end else if (shift_en) begin
      chain_nxt = chain_q >> 1;
      chain_nxt[model_len-1] = ccff_head;
      chain_q <= chain_nxt;
    end
  end
  assign ccff_tail = chain_q[0];

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_w;
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- monitor (negedge, away from active edge) ----------------
  int   shift_total = 0;
  int   stall_total = 0;
  int   rise_total  = 0;
  int   done_total  = 0;
  int   rise_cyc    = 0;
  int   xfer_cyc    = 0;
  int   done_cyc    = 0;
  logic prev_valid  = 1'b0;

  always @(negedge clk) begin
    if (shift_en) shift_total++;
    if (dbg_state == 2'd1 && !shift_en && !reset) stall_total++;
    if (rd_valid && !prev_valid) begin
      rise_total++;
      rise_cyc = cyc;
    end
    prev_valid = rd_valid;
    if (rd_valid && rd_ready) begin
      xfer_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("unexpected_word", {32'd0, rd_data}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        exp_w = exp_q.pop_front();
        check("rd_data", {32'd0, rd_data}, {32'd0, exp_w});
      end
    end
    if (done) begin
      done_total++;
      done_cyc = cyc;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic preload(input logic [127:0] v, input int len);
    load_val  = v;
    model_len = len;
    load_req  = 1'b1;
    tick();
    load_req  = 1'b0;
  endtask

  // Returns the cycle-counter value seen during cycle 1 (the cycle after the
  // edge that samples start).
  task automatic start_pass(input int len, output int c0);
    chain_len = LW'(len);
    start     = 1'b1;
    tick();
    start     = 1'b0;
    c0        = cyc;
  endtask

  task automatic wait_done(input int base, input string name);
    int n;
    n = 0;
    while (done_total == base && n < 400) begin
      tick();
      n++;
    end
    check(name, (done_total != base) ? 64'd1 : 64'd0, 64'd1);
  endtask

  // ---------------- stimulus ----------------
  int c0, s0, r0, d0, st0, n;

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    chain_len = '0;
    rd_ready  = 1'b0;
    load_val  = '0;
    chain_q   = '0;
    repeat (3) tick();

    // reset values
    check("rst_shift_en", {63'd0, shift_en}, 64'd0);
    check("rst_ccff_head", {63'd0, ccff_head}, 64'd0);
    check("rst_rd_valid", {63'd0, rd_valid}, 64'd0);
    check("rst_rd_data", {32'd0, rd_data}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_state", {62'd0, dbg_state}, 64'd0);
    reset = 1'b0;
    tick();

    // single full word, ready held high
    rd_ready = 1'b1;
    preload(128'hA5A5_0F0F, 32);
    exp_q.push_back(32'hA5A5_0F0F);
    s0 = shift_total; d0 = done_total;
    start_pass(32, c0);
    wait_done(d0, "t1_done_timeout");
    check("t1_shift_cycles", 64'(shift_total - s0), 64'd32);
    check("t1_first_valid_cycle", 64'(rise_cyc - c0 + 1), 64'd33);
    check("t1_done_after_xfer", 64'(done_cyc - xfer_cyc), 64'd1);
    tick();
    check("t1_idle_busy", {63'd0, busy}, 64'd0);

    // 40 bits: one full word plus an 8-bit tail word
    preload(128'hC3_89AB_CDEF, 40);
    exp_q.push_back(32'h89AB_CDEF);
    exp_q.push_back(32'h0000_00C3);
    s0 = shift_total; r0 = rise_total; d0 = done_total;
    start_pass(40, c0);
    wait_done(d0, "t2_done_timeout");
    check("t2_shift_cycles", 64'(shift_total - s0), 64'd40);
    check("t2_word_count", 64'(rise_total - r0), 64'd2);
    tick();

    // 64 bits with the consumer stalled across the second word's completion
    rd_ready = 1'b0;
    preload(128'h0123_4567_89AB_CDEF, 64);
    exp_q.push_back(32'h89AB_CDEF);
    exp_q.push_back(32'h0123_4567);
    s0 = shift_total; st0 = stall_total; d0 = done_total;
    start_pass(64, c0);
    n = 0;
    while (!rd_valid && n < 100) begin
      tick();
      n++;
    end
    check("t3_first_word_timeout", {63'd0, rd_valid}, 64'd1);
    repeat (41) tick();
    check("t3_shifts_frozen", 64'(shift_total - s0), 64'd63);
    check("t3_stall_cycles", 64'(stall_total - st0), 64'd10);
    check("t3_shift_en_low", {63'd0, shift_en}, 64'd0);
    rd_ready = 1'b1;
    wait_done(d0, "t3_done_timeout");
    check("t3_shift_cycles", 64'(shift_total - s0), 64'd64);
    tick();

    // empty chain
    s0 = shift_total; r0 = rise_total; d0 = done_total;
    start_pass(0, c0);
    wait_done(d0, "t4_done_timeout");
    check("t4_shift_cycles", 64'(shift_total - s0), 64'd0);
    check("t4_words", 64'(rise_total - r0), 64'd0);
    check("t4_done_cycle", 64'(done_cyc - c0 + 1), 64'd1);
    tick();

    // reset after 12 of 32 shifts, then a clean pass
    preload(128'hDEAD_BEEF, 32);
    s0 = shift_total; d0 = done_total;
    start_pass(32, c0);
    n = 0;
    while ((shift_total - s0) < 12 && n < 100) begin
      tick();
      n++;
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("t5_shift_en", {63'd0, shift_en}, 64'd0);
    check("t5_ccff_head", {63'd0, ccff_head}, 64'd0);
    check("t5_rd_valid", {63'd0, rd_valid}, 64'd0);
    check("t5_rd_data", {32'd0, rd_data}, 64'd0);
    check("t5_busy", {63'd0, busy}, 64'd0);
    check("t5_done", {63'd0, done}, 64'd0);
    check("t5_shifts_before_abort", 64'(shift_total - s0), 64'd12);
    repeat (5) tick();
    check("t5_no_done", 64'(done_total - d0), 64'd0);
    preload(128'hCAFE_F00D, 32);
    exp_q.push_back(32'hCAFE_F00D);
    s0 = shift_total; d0 = done_total;
    start_pass(32, c0);
    wait_done(d0, "t5_restart_timeout");
    check("t5_restart_shifts", 64'(shift_total - s0), 64'd32);
    tick();

    // back-to-back passes over the same chain
    preload(128'h1234_5678, 32);
    exp_q.push_back(32'h1234_5678);
    d0 = done_total;
    start_pass(32, c0);
    wait_done(d0, "t6_pass1_timeout");
    tick();
`ifdef CCFF_READBACK_RESTORE_EN
    exp_q.push_back(32'h1234_5678);
`else
    exp_q.push_back(32'h0000_0000);
`endif
    d0 = done_total;
    start_pass(32, c0);
    wait_done(d0, "t6_pass2_timeout");
    repeat (2) tick();

    check("words_outstanding", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ccff_readback_ctrl.md
CCFF_READBACK_CTRL -- requirements
Module: ccff_readback_ctrl

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset, named clk and reset.
REQ-002 Parameter DATA_W SHALL default to 32 and set the readback word width in bits.
REQ-003 Parameter LEN_W SHALL default to 16 and set the chain-length width in bits.
REQ-004 Port clk SHALL be an input, 1 bit wide, and SHALL serve as the single clock; all logic samples on its rising edge.
REQ-005 Port reset SHALL be an input, 1 bit wide, and SHALL be the synchronous, active-high reset.
REQ-006 Port start SHALL be an input, 1 bit wide, and SHALL request a readback pass; it is sampled only in IDLE.
REQ-007 Port chain_len SHALL be an input, LEN_W bits wide, and SHALL give the number of configuration flip-flops in the chain.
REQ-008 Port ccff_tail SHALL be an input, 1 bit wide, and SHALL carry the serial output of the last chain flip-flop.
REQ-009 Port shift_en SHALL be an output, 1 bit wide, and SHALL be the chain shift enable; the chain advances one bit per clk edge while it is high.
REQ-010 Port ccff_head SHALL be an output, 1 bit wide, and SHALL drive the serial input into the first chain flip-flop.
REQ-011 Port rd_data SHALL be an output, DATA_W bits wide, and SHALL carry the packed readback word.
REQ-012 Port rd_valid SHALL be an output, 1 bit wide, and SHALL indicate that rd_data holds an unconsumed word.
REQ-013 Port rd_ready SHALL be an input, 1 bit wide, and SHALL indicate that the consumer accepts rd_data.
REQ-014 Port busy SHALL be an output, 1 bit wide, and SHALL be high in every state except IDLE.
REQ-015 Port done SHALL be an output, 1 bit wide, and SHALL pulse high for exactly one cycle when a pass completes.

Function
REQ-016 The FSM SHALL have exactly four states: IDLE, SHIFT, DRAIN and FINISH.
REQ-017 IDLE with start=1 and chain_len!=0 SHALL latch chain_len, clear the bit counter and go to SHIFT; shift_en rises in the next cycle.
REQ-018 IDLE with start=1 and chain_len=0 SHALL go to FINISH with no shifts and no words.
REQ-019 In SHIFT, each cycle with shift_en=1 SHALL capture ccff_tail into the packer at bit index (count mod DATA_W), LSB first, and increment count.
REQ-020 A word SHALL be complete after DATA_W captured bits or after the final bit (count = latched length).
REQ-021 Upper bits of a partial final word SHALL be zero.
REQ-022 A completed word SHALL load the output register in the same edge if rd_valid=0 or rd_ready=1; rd_valid is then high in the following cycle.
REQ-023 shift_en SHALL be low in any cycle where a word would complete while the output register is full and rd_ready=0; no bit is lost or duplicated.
REQ-024 rd_data SHALL stay stable while rd_valid=1 and rd_ready=0; a transfer occurs on an edge with both high.
REQ-025 After the final bit is captured, the FSM SHALL go to DRAIN, then to FINISH once the last word has transferred.
REQ-026 FINISH SHALL assert done for one cycle and return to IDLE.
REQ-027 start SHALL be ignored while busy=1.
REQ-028 Timing with rd_ready held high: start sampled at edge 0, shifts on cycles 1..DATA_W, first rd_valid in cycle DATA_W+1.

Reset
REQ-029 Reset SHALL force state=IDLE, count=0, packer cleared, shift_en=0, ccff_head=0, rd_valid=0, rd_data=0, busy=0 and done=0.
REQ-030 Reset mid-pass SHALL abort the pass immediately, with no done pulse, discard any pending word, and leave the chain contents as left by the shifts already performed.

Configuration
REQ-031 With CCFF_READBACK_RESTORE_EN defined, ccff_head SHALL equal ccff_tail whenever shift_en=1, so that a complete pass leaves the chain contents unchanged.
REQ-032 Without CCFF_READBACK_RESTORE_EN, ccff_head SHALL be constant 0, so that a pass is destructive and the chain reads all zeros afterwards.

Structure
REQ-033 Package ccff_readback_pkg SHALL hold the state enum type and the default DATA_W and LEN_W constants.
REQ-034 Serial-to-parallel packing SHALL be a sub-module, ccff_readback_packer, with inputs bit, valid and clear, and outputs word and full.

Verification
REQ-035 chain_len=32, chain preloaded 0xA5A5_0F0F, rd_ready=1 -> one word rd_data=0xA5A5_0F0F, exactly 32 shift_en cycles, done one cycle after the transfer.
REQ-036 chain_len=40, rd_ready=1 -> two words; the second carries only bits [7:0], with [31:8]=0.
REQ-037 chain_len=64, rd_ready held low for 10 cycles after the first word -> shift_en low during the stall, second word correct, total shift_en cycles = 64.
REQ-038 chain_len=0 and start pulse -> no shift_en, no rd_valid, done one cycle later.
REQ-039 Reset asserted at shift 12 of 32 -> all outputs at reset values the next cycle, no done; a new start then works normally.
REQ-040 With the macro defined, two back-to-back passes SHALL return identical words; without it, the second pass SHALL return all zeros.
